// File: rtl/adam_periph_uart_autobaud.sv
// UART auto-baud calibrator: pauses the datapath, times a 0x55 sync character and
// publishes clk-cycles-per-bit. Define ADAM_UART_AUTOBAUD_SYNC_EN to synchronize rx.
module adam_periph_uart_autobaud #(
    parameter int DATA_WIDTH = 32,
    parameter int MIN_DIV    = 4,
    parameter int TIMEOUT    = 2**20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rx,
    output logic                  pause_req,
    input  logic                  pause_ack,
    output logic [DATA_WIDTH-1:0] baud_rate,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {IDLE, PAUSE, WAIT_START, MEASURE, RELEASE} state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] baud_q;
    logic [1:0]            edges_q;
    logic                  rx_prev_q;
    logic                  pause_req_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;

    logic                  rx_s;
    logic                  fall;
    logic [DATA_WIDTH+2:0] sum;
    logic [DATA_WIDTH-1:0] result;
    logic                  timeout_hit;

`ifdef ADAM_UART_AUTOBAUD_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], rx};
    end
    assign rx_s = sync_q[1];
`else
    assign rx_s = rx;
`endif

    assign fall        = rx_prev_q & ~rx_s;
    // 8 bit times span the 1st..5th falling edge; add half an LSB to round.
    assign sum         = {3'b000, cnt_q} + (DATA_WIDTH+3)'(4);
    assign result      = DATA_WIDTH'(sum >> 3);
    assign timeout_hit = (cnt_q >= DATA_WIDTH'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            baud_q      <= '0;
            edges_q     <= '0;
            rx_prev_q   <= 1'b1;
            pause_req_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            rx_prev_q <= rx_s;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= PAUSE;
                        pause_req_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (pause_ack) state_q <= WAIT_START;
                end
                WAIT_START: begin
                    if (fall) begin
                        state_q <= MEASURE;
                        cnt_q   <= DATA_WIDTH'(1);
                        edges_q <= '0;
                    end
                end
                MEASURE: begin
                    cnt_q <= cnt_q + DATA_WIDTH'(1);
                    // Timeout is checked first so it wins over a coincident edge.
                    if (timeout_hit) begin
                        error_q     <= 1'b1;
                        state_q     <= RELEASE;
                        pause_req_q <= 1'b0;
                    end else if (fall) begin
                        if (edges_q == 2'd3) begin
                            if (result >= DATA_WIDTH'(MIN_DIV)) begin
                                baud_q <= result;
                                done_q <= 1'b1;
                            end else begin
                                error_q <= 1'b1;
                            end
                            state_q     <= RELEASE;
                            pause_req_q <= 1'b0;
                        end else begin
                            edges_q <= edges_q + 2'd1;
                        end
                    end
                end
                RELEASE: begin
                    if (!pause_ack) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    pause_req_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign pause_req = pause_req_q;
    assign baud_rate = baud_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_adam_periph_uart_autobaud.sv
// Bench for adam_periph_uart_autobaud: table vectors, randomized sync characters against a
// timing model, plus timeout, busy-start and reset-abort sequences on two instances.
module tb_adam_periph_uart_autobaud;

    localparam int DW      = 32;
    localparam int MIN_DIV = 4;
    localparam int TO      = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic rx = 1'b1;
    logic pause_ack = 1'b0;

    logic          pause_req, busy, done, error;
    logic [DW-1:0] baud_rate;
    logic          preq_to, busy_to, done_to, err_to;
    logic [DW-1:0] baud_to;

    int passed = 0, total = 0;
    int done_cnt = 0, err_cnt = 0, done_to_cnt = 0, err_to_cnt = 0, overlap = 0;
    longint exp_baud = 0, exp_to = 0;

    typedef struct {
        int     p;
        longint exp_baud;
        bit     exp_done;
    } vec_t;

    vec_t tbl[5];
    int   len[10];
    bit   got_ok;

    adam_periph_uart_autobaud #(.DATA_WIDTH(DW), .MIN_DIV(MIN_DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .rx(rx),
        .pause_req(pause_req), .pause_ack(pause_ack), .baud_rate(baud_rate),
        .busy(busy), .done(done), .error(error)
    );

    adam_periph_uart_autobaud #(.DATA_WIDTH(DW), .MIN_DIV(MIN_DIV), .TIMEOUT(TO)) dut_to (
        .clk(clk), .rst(rst), .start(start), .rx(rx),
        .pause_req(preq_to), .pause_ack(pause_ack), .baud_rate(baud_to),
        .busy(busy_to), .done(done_to), .error(err_to)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (done)            done_cnt++;
        if (error)           err_cnt++;
        if (done_to)         done_to_cnt++;
        if (err_to)          err_to_cnt++;
        if (done && error)   overlap++;
        if (done_to && err_to) overlap++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One full calibration: expected outcome from the edge-to-edge span of the frame.
    task automatic calib(input string name, input int l[10], input int hold, input bit spam,
                         output bit ok_out);
        int cnt, res, d0, e0, t0;
        bit ok, ok_to;
        cnt = 0;
        for (int i = 0; i < 8; i++) cnt += l[i];
        res   = (cnt + 4) / 8;
        ok    = (res >= MIN_DIV);
        ok_to = ok && (cnt < TO);
        d0 = done_cnt; e0 = err_cnt; t0 = done_to_cnt + err_to_cnt;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, " pause_req raised"}, pause_req, 1);
        for (int i = 0; i < hold; i++) begin
            start = spam && (i % 10 == 5);
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, " busy in PAUSE"}, busy, 1);
        chk({name, " no pulse in PAUSE"}, done_cnt + err_cnt - d0 - e0, 0);

        pause_ack = 1'b1;
        repeat (2) @(negedge clk);
        for (int b = 0; b < 10; b++) begin
            rx = (b % 2 == 1);
            repeat (l[b]) @(negedge clk);
        end
        rx = 1'b1;
        repeat (8) @(negedge clk);

        if (ok) exp_baud = res;
        if (ok_to) exp_to = res;
        chk({name, " done pulses"}, done_cnt - d0, ok ? 1 : 0);
        chk({name, " error pulses"}, err_cnt - e0, ok ? 0 : 1);
        chk({name, " baud_rate"}, baud_rate, exp_baud);
        chk({name, " pause_req dropped"}, pause_req, 0);
        chk({name, " to-inst one pulse"}, done_to_cnt + err_to_cnt - t0, 1);
        chk({name, " to-inst baud_rate"}, baud_to, exp_to);

        pause_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk({name, " idle after release"}, busy, 0);
        ok_out = ((done_cnt - d0) == 1);
    endtask

    initial begin
        int n;
        bit got;
        tbl[0] = '{434, 434, 1'b1};
        tbl[1] = '{2,   434, 1'b0};
        tbl[2] = '{4,   4,   1'b1};
        tbl[3] = '{3,   4,   1'b0};
        tbl[4] = '{100, 100, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset pause_req", pause_req, 0);
        chk("reset done", done, 0);
        chk("reset error", error, 0);
        chk("reset baud_rate", baud_rate, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            for (int b = 0; b < 10; b++) len[b] = tbl[i].p;
            calib($sformatf("tbl%0d", i), len, 3, 1'b0, got_ok);
            chk($sformatf("tbl%0d outcome", i), got_ok, tbl[i].exp_done);
            chk($sformatf("tbl%0d table baud", i), baud_rate, tbl[i].exp_baud);
        end

        // Start pulses while busy and a long unacknowledged pause must be ignored.
        for (int b = 0; b < 10; b++) len[b] = 8;
        calib("spam", len, 100, 1'b1, got_ok);

        // Fifth edge exactly on the timeout cycle of the short-timeout instance, then one before.
        for (int b = 0; b < 10; b++) len[b] = 125;
        calib("edge@timeout", len, 3, 1'b0, got_ok);
        len[0] = 124;
        calib("edge<timeout", len, 3, 1'b0, got_ok);

        for (int r = 0; r < 8; r++) begin
            int p;
            p = int'($urandom_range(2, 40));
            for (int b = 0; b < 10; b++) len[b] = p + int'($urandom_range(0, 3));
            calib($sformatf("rand%0d", r), len, int'($urandom_range(1, 6)), 1'b0, got_ok);
        end

        for (int b = 0; b < 10; b++) len[b] = 5208;
        calib("9600", len, 3, 1'b0, got_ok);

        // Single falling edge then rx stuck low: short-timeout instance must give up.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        pause_ack = 1'b1;
        repeat (2) @(negedge clk);
        rx = 1'b0;
        n = 0; got = 1'b0;
        while (n < 1100 && !got) begin
            @(negedge clk);
            n++;
            if (err_to) got = 1'b1;
        end
        chk("timeout error seen", got, 1);
        chk("timeout latency in window", (n >= TO && n <= TO + 4), 1);
        chk("timeout baud kept", baud_to, exp_to);
        chk("main still busy", busy, 1);

        // Abort the main instance mid-measurement.
        rst = 1'b0;
        @(negedge clk);
        chk("abort pause_req", pause_req, 0);
        chk("abort busy", busy, 0);
        chk("abort baud_rate", baud_rate, 0);
        rst = 1'b1;
        rx = 1'b1;
        pause_ack = 1'b0;
        exp_baud = 0;
        exp_to = 0;
        repeat (2) @(negedge clk);
        for (int b = 0; b < 10; b++) len[b] = 16;
        calib("post-reset", len, 3, 1'b0, got_ok);
        chk("post-reset done", got_ok, 1);

        chk("no done/error overlap", overlap, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
